// File: rtl/alu_issue_unit.sv
// alu_issue_unit
// ----------------------------------------------------------------------------
// Purpose:
//   Single-entry issue stage for a MIPS-style integer ALU. One instruction is
//   accepted in IDLE, decoded into ALU operands/control. The external ALU
//   result is captured in EXEC, and the result is held in DONE until
//   downstream consumes it.
//   FSM: IDLE -> EXEC -> DONE -> IDLE, so the best case is one instruction
//   every three cycles.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid / in_ready          upstream handshake (ready only in IDLE)
//   instr, rs_val, rt_val        instruction word and register operands
//   alu_a, alu_b, alu_ctrl       registered operands/control to the ALU
//   alu_out, alu_zero,
//   alu_overflow                 combinational ALU response
//   res_valid / res_ready        downstream handshake (valid only in DONE)
//   res_data, res_zero           captured ALU result and zero flag
//   res_wen                      result should be written back
//   res_exc                      overflow trap on ADD/SUB/ADDI
//   res_illegal                  undecodable instruction
//   exc_count                    saturating count of traps + illegal instrs
// ----------------------------------------------------------------------------
module alu_issue_unit #(
    parameter int EXC_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [31:0]          rs_val,
    input  logic [31:0]          rt_val,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [3:0]           alu_ctrl,
    input  logic [31:0]          alu_out,
    input  logic                 alu_zero,
    input  logic                 alu_overflow,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_data,
    output logic                 res_zero,
    output logic                 res_wen,
    output logic                 res_exc,
    output logic                 res_illegal,
    output logic [EXC_CNT_W-1:0] exc_count
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t state_reg, state_next;

    logic [31:0]          alu_a_reg, alu_b_reg;
    logic [3:0]           alu_ctrl_reg;
    logic                 trap_en_reg, wen_reg, illegal_reg;
    logic [31:0]          res_data_reg;
    logic                 res_zero_reg, res_wen_reg, res_exc_reg, res_illegal_reg;
    logic [EXC_CNT_W-1:0] exc_count_reg;

    // Decoder outputs
    logic [31:0] dec_a, dec_b;
    logic [3:0]  dec_ctrl;
    logic        dec_trap, dec_wen, dec_illegal;

    logic [5:0]  opcode, funct;
    logic [31:0] imm_sext, imm_zext;
    logic        exc_now;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};
    assign imm_zext = {16'h0000, instr[15:0]};

    // Defaults describe the illegal case; each legal encoding overrides them.
    always_comb begin
        dec_a       = 32'h0;
        dec_b       = 32'h0;
        dec_ctrl    = 4'b1111;
        dec_trap    = 1'b0;
        dec_wen     = 1'b0;
        dec_illegal = 1'b1;
        if (opcode == 6'h00) begin
            case (funct)
                6'h24: begin dec_ctrl = 4'b0000; dec_illegal = 1'b0; end
                6'h25: begin dec_ctrl = 4'b0001; dec_illegal = 1'b0; end
                6'h20: begin dec_ctrl = 4'b0010; dec_illegal = 1'b0; dec_trap = 1'b1; end
                6'h21: begin dec_ctrl = 4'b0010; dec_illegal = 1'b0; end
                6'h22: begin dec_ctrl = 4'b0110; dec_illegal = 1'b0; dec_trap = 1'b1; end
                6'h23: begin dec_ctrl = 4'b0110; dec_illegal = 1'b0; end
                6'h2A: begin dec_ctrl = 4'b0111; dec_illegal = 1'b0; end
                6'h27: begin dec_ctrl = 4'b1100; dec_illegal = 1'b0; end
                default: ;
            endcase
            if (!dec_illegal) begin
                dec_a   = rs_val;
                dec_b   = rt_val;
                dec_wen = 1'b1;
            end
        end else begin
            case (opcode)
                6'h08: begin dec_ctrl = 4'b0010; dec_b = imm_sext; dec_illegal = 1'b0; dec_trap = 1'b1; end
                6'h09: begin dec_ctrl = 4'b0010; dec_b = imm_sext; dec_illegal = 1'b0; end
                6'h0A: begin dec_ctrl = 4'b0111; dec_b = imm_sext; dec_illegal = 1'b0; end
                6'h0C: begin dec_ctrl = 4'b0000; dec_b = imm_zext; dec_illegal = 1'b0; end
                6'h0D: begin dec_ctrl = 4'b0001; dec_b = imm_zext; dec_illegal = 1'b0; end
                6'h04: begin dec_ctrl = 4'b0110; dec_b = rt_val;   dec_illegal = 1'b0; end
                default: ;
            endcase
            if (!dec_illegal) begin
                dec_a   = rs_val;
                // BEQ only produces a zero flag; nothing is written back.
                dec_wen = (opcode != 6'h04);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign exc_now = trap_en_reg && alu_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            alu_a_reg       <= 32'h0;
            alu_b_reg       <= 32'h0;
            alu_ctrl_reg    <= 4'b0000;
            trap_en_reg     <= 1'b0;
            wen_reg         <= 1'b0;
            illegal_reg     <= 1'b0;
            res_data_reg    <= 32'h0;
            res_zero_reg    <= 1'b0;
            res_wen_reg     <= 1'b0;
            res_exc_reg     <= 1'b0;
            res_illegal_reg <= 1'b0;
            exc_count_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        alu_a_reg    <= dec_a;
                        alu_b_reg    <= dec_b;
                        alu_ctrl_reg <= dec_ctrl;
                        trap_en_reg  <= dec_trap;
                        wen_reg      <= dec_wen;
                        illegal_reg  <= dec_illegal;
                    end
                end
                EXEC: begin
                    res_data_reg    <= alu_out;
                    res_zero_reg    <= alu_zero;
                    res_exc_reg     <= exc_now;
                    res_illegal_reg <= illegal_reg;
                    // wen_reg is already low for illegal and BEQ.
                    res_wen_reg     <= wen_reg && !exc_now;
                    if ((exc_now || illegal_reg) && (exc_count_reg != '1))
                        exc_count_reg <= exc_count_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state_reg == IDLE);
    assign res_valid   = (state_reg == DONE);
    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;
    assign alu_ctrl    = alu_ctrl_reg;
    assign res_data    = res_data_reg;
    assign res_zero    = res_zero_reg;
    assign res_wen     = res_wen_reg;
    assign res_exc     = res_exc_reg;
    assign res_illegal = res_illegal_reg;
    assign exc_count   = exc_count_reg;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Testbench for alu_issue_unit. Models the external ALU combinationally and
// checks every completed instruction against a scoreboard queue.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'h0, rs_val = 32'h0, rt_val = 32'h0;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        alu_zero, alu_overflow;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic        res_zero, res_wen, res_exc, res_illegal;
    logic [7:0]  exc_count;

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] exp_exc = 8'd0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] data;
        logic        zero;
        logic        wen;
        logic        exc;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_issue_unit #(.EXC_CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_zero(res_zero), .res_wen(res_wen),
        .res_exc(res_exc), .res_illegal(res_illegal), .exc_count(exc_count)
    );

    // Reference ALU (MIPS control codes)
    function automatic logic [32:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic        ov;
        r  = 32'h0;
        ov = 1'b0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            4'b0110: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            default: r = 32'h0;
        endcase
        return {ov, r};
    endfunction

    always_comb begin
        logic [32:0] t;
        t            = ref_alu(alu_ctrl, alu_a, alu_b);
        alu_out      = t[31:0];
        alu_overflow = t[32];
        alu_zero     = (t[31:0] == 32'h0);
    end

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                                input logic [31:0] d, input logic z, input logic w,
                                input logic x, input logic il);
        exp_t e;
        e.a = a; e.b = b; e.ctrl = c; e.data = d; e.zero = z; e.wen = w; e.exc = x; e.ill = il;
        return e;
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] f);
        return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    // Expected result for a legal instruction, built from the instruction table.
    function automatic exp_t ref_instr(input logic [31:0] ins, input logic [31:0] rs,
                                       input logic [31:0] rt);
        logic [3:0]  c;
        logic [31:0] b;
        logic        trap, w;
        logic [32:0] r;
        c = 4'b1111; b = rt; trap = 1'b0; w = 1'b1;
        if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h24: c = 4'b0000;
                6'h25: c = 4'b0001;
                6'h20: begin c = 4'b0010; trap = 1'b1; end
                6'h21: c = 4'b0010;
                6'h22: begin c = 4'b0110; trap = 1'b1; end
                6'h23: c = 4'b0110;
                6'h2A: c = 4'b0111;
                default: c = 4'b1100;
            endcase
        end else begin
            case (ins[31:26])
                6'h08: begin c = 4'b0010; b = {{16{ins[15]}}, ins[15:0]}; trap = 1'b1; end
                6'h09: begin c = 4'b0010; b = {{16{ins[15]}}, ins[15:0]}; end
                6'h0A: begin c = 4'b0111; b = {{16{ins[15]}}, ins[15:0]}; end
                6'h0C: begin c = 4'b0000; b = {16'h0, ins[15:0]}; end
                6'h0D: begin c = 4'b0001; b = {16'h0, ins[15:0]}; end
                default: begin c = 4'b0110; w = 1'b0; end
            endcase
        end
        r = ref_alu(c, rs, b);
        return mk(rs, b, c, r[31:0], r[31:0] == 32'h0, w && !(trap && r[32]),
                  trap && r[32], 1'b0);
    endfunction

    // Present one instruction, wait for acceptance, check the issued operands.
    task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                         input exp_t e);
        int n = 0;
        instr = ins; rs_val = rs; rt_val = rt; in_valid = 1'b1;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        tests_run++;
        if (!in_ready) begin
            tests_failed++;
            $display("FAIL accept_timeout: in_ready got %b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(e);
        tests_run++;
        if ({alu_a, alu_b, alu_ctrl} !== {e.a, e.b, e.ctrl}) begin
            tests_failed++;
            $display("FAIL issue_operands: a/b/ctrl got %h/%h/%b required %h/%h/%b",
                     alu_a, alu_b, alu_ctrl, e.a, e.b, e.ctrl);
        end
        tests_run++;
        if (res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL exec_no_valid: res_valid got %b required 0", res_valid);
        end
    endtask

    // Wait for res_valid, pop the scoreboard and compare (res_ready assumed high).
    task automatic collect();
        int n = 0;
        exp_t e;
        while (!res_valid && n < 10) begin @(posedge clk); #1; n++; end
        tests_run++;
        if (!res_valid || sb.size() == 0) begin
            tests_failed++;
            $display("FAIL result_timeout: res_valid got %b required 1 (queue %0d)",
                     res_valid, sb.size());
            return;
        end
        e = sb.pop_front();
        if ((e.exc || e.ill) && exp_exc != 8'hFF) exp_exc++;
        tests_run++;
        if ({res_data, res_zero, res_wen, res_exc, res_illegal} !==
            {e.data, e.zero, e.wen, e.exc, e.ill}) begin
            tests_failed++;
            $display("FAIL result: data/zero/wen/exc/ill got %h/%b/%b/%b/%b required %h/%b/%b/%b/%b",
                     res_data, res_zero, res_wen, res_exc, res_illegal,
                     e.data, e.zero, e.wen, e.exc, e.ill);
        end
        tests_run++;
        if (exc_count !== exp_exc) begin
            tests_failed++;
            $display("FAIL exc_count: got %0d required %0d", exc_count, exp_exc);
        end
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL back_to_idle: in_ready/res_valid got %b/%b required 1/0",
                     in_ready, res_valid);
        end
    endtask

    task automatic run_one(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                           input exp_t e);
        $display("[TB] instr=%h rs=%h rt=%h", ins, rs, rt);
        issue(ins, rs, rt, e);
        collect();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tests_run++;
        if ({in_ready, res_valid, alu_ctrl, exc_count, res_data} !== {1'b1, 1'b0, 4'b0000, 8'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_state: ready/valid/ctrl/cnt/data got %b/%b/%b/%0d/%h required 1/0/0000/0/0",
                     in_ready, res_valid, alu_ctrl, exc_count, res_data);
        end
    endtask

    task automatic test_add_overflow();
        run_one(rtype(6'h20), 32'h7FFFFFFF, 32'h1,
                mk(32'h7FFFFFFF, 32'h1, 4'b0010, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0));
        run_one(rtype(6'h21), 32'h7FFFFFFF, 32'h1,
                mk(32'h7FFFFFFF, 32'h1, 4'b0010, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0));
    endtask

    task automatic test_immediates();
        run_one(itype(6'h0C, 16'hFFFF), 32'h12345678, 32'h0,
                mk(32'h12345678, 32'h0000FFFF, 4'b0000, 32'h00005678, 1'b0, 1'b1, 1'b0, 1'b0));
        run_one(itype(6'h0A, 16'hFFFF), 32'h0, 32'h0,
                mk(32'h0, 32'hFFFFFFFF, 4'b0111, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0));
    endtask

    task automatic test_beq();
        run_one(itype(6'h04, 16'h0010), 32'd5, 32'd5,
                mk(32'd5, 32'd5, 4'b0110, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic test_illegal();
        run_one({6'h3F, 26'h0ABCDEF}, 32'h1234, 32'h5678,
                mk(32'h0, 32'h0, 4'b1111, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic test_random_ops();
        logic [5:0] fn[8] = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h27};
        logic [5:0] op[6] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h04};
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ins, rs, rt;
            rs = $urandom; rt = $urandom;
            if (i % 5 == 0) rt = rs;
            if (i % 2 == 0) ins = rtype(fn[$urandom_range(0, 7)]);
            else            ins = itype(op[$urandom_range(0, 5)], 16'($urandom));
            run_one(ins, rs, rt, ref_instr(ins, rs, rt));
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++)
            run_one({6'h3F, 26'h0}, 32'h0, 32'h0,
                    mk(32'h0, 32'h0, 4'b1111, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1));
        tests_run++;
        if (exc_count !== 8'hFF) begin
            tests_failed++;
            $display("FAIL exc_saturate: got %0d required 255", exc_count);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int n = 0;
        exp_t e;
        res_ready = 1'b0;
        issue(rtype(6'h21), 32'd100, 32'd23,
              mk(32'd100, 32'd23, 4'b0010, 32'd123, 1'b0, 1'b1, 1'b0, 1'b0));
        while (!res_valid && n < 10) begin @(posedge clk); #1; n++; end
        e = sb.pop_front();
        held = res_data;
        tests_run++;
        if (res_valid !== 1'b1 || res_data !== e.data) begin
            tests_failed++;
            $display("FAIL bp_result: valid/data got %b/%h required 1/%h", res_valid, res_data, e.data);
        end
        instr = rtype(6'h25); rs_val = 32'hF0; rt_val = 32'h0F; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({res_valid, res_data, in_ready} !== {1'b1, held, 1'b0}) begin
                tests_failed++;
                $display("FAIL bp_stall%0d: valid/data/ready got %b/%h/%b required 1/%h/0",
                         i, res_valid, res_data, in_ready, held);
            end
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({res_valid, in_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL bp_release: valid/ready got %b/%b required 0/1", res_valid, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_ignored_in: res_valid got %b required 0", res_valid);
        end
        $display("[TB] backpressure transaction data=%h", held);
    endtask

    task automatic test_reset_mid();
        issue(rtype(6'h25), 32'hAAAA0000, 32'h00005555,
              mk(32'hAAAA0000, 32'h00005555, 4'b0001, 32'hAAAA5555, 1'b0, 1'b1, 1'b0, 1'b0));
        #2 rst = 1'b1;
        #1;
        void'(sb.pop_front());
        exp_exc = 8'd0;
        tests_run++;
        if ({res_valid, alu_a, alu_b, alu_ctrl, exc_count, in_ready} !==
            {1'b0, 32'h0, 32'h0, 4'b0000, 8'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL async_reset: valid/a/b/ctrl/cnt/ready got %b/%h/%h/%b/%0d/%b required 0/0/0/0000/0/1",
                     res_valid, alu_a, alu_b, alu_ctrl, exc_count, in_ready);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_drop: res_valid got %b required 0", res_valid);
        end
        run_one(rtype(6'h22), 32'h80000000, 32'h1,
                mk(32'h80000000, 32'h1, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0));
        run_one(rtype(6'h27), 32'h0F0F0000, 32'h000000FF,
                mk(32'h0F0F0000, 32'h000000FF, 4'b1100, 32'hF0F0FF00, 1'b0, 1'b1, 1'b0, 1'b0));
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_immediates();
        test_beq();
        test_illegal();
        test_random_ops();
        test_backpressure();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
